// File: rtl/pipe_stage_reg.sv
// Purpose : pipeline stage register with bubble/flush, exception redirect, stall hold and T_new ageing.
// Latency : one cycle; every output is a flop, no combinational path from inputs to outputs.
// Backpress: stall holds contents (STALL_MODE=0) or inserts a bubble (STALL_MODE=1); req > flush > stall > load.
module pipe_stage_reg #(
    parameter int          DW         = 32,
    parameter int          NCH        = 4,
    parameter int          TW         = 2,
    parameter int          STALL_MODE = 0,
    parameter logic [31:0] EXC_PC     = 32'h0000_4180
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                req,
    input  logic                in_valid,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_instr,
    input  logic [TW-1:0]       in_tnew,
    input  logic [NCH*DW-1:0]   in_data,
    input  logic                in_bd,
    input  logic [4:0]          in_exccode,
    output logic                out_valid,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_instr,
    output logic [TW-1:0]       out_tnew,
    output logic [NCH*DW-1:0]   out_data,
    output logic                out_bd,
    output logic [4:0]          out_exccode,
    output logic [7:0]          out_hold_cnt
);

    // Complete architectural content of the stage, kept as one packed record.
    typedef struct packed {
        logic                valid;
        logic [31:0]         pc;
        logic [31:0]         instr;
        logic [TW-1:0]       tnew;
        logic [NCH*DW-1:0]   data;
        logic                bd;
        logic [4:0]          exccode;
    } stage_t;

    // What the stage does at the next edge (reset is handled in the register itself).
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_REQ   = 2'd3
    } act_t;

    localparam logic [7:0] HOLD_MAX = 8'hFF;

    stage_t     cur_q;
    stage_t     nxt;
    logic [7:0] hold_q;
    logic [7:0] nxt_hold;
    act_t       act;

    // T_new counts down towards zero and never wraps.
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t != '0) ? (t - TW'(1)) : '0;
    endfunction

    // Resolve the control inputs by priority; in bubble mode a stall behaves exactly like a flush.
    always_comb begin
        act = ACT_LOAD;
        if (req) begin
            act = ACT_REQ;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = (STALL_MODE != 0) ? ACT_FLUSH : ACT_HOLD;
        end
    end

    // Next stage content and hold counter for the selected action.
    always_comb begin
        nxt      = cur_q;
        nxt_hold = 8'd0;
        case (act)
            ACT_REQ: begin
                // Exception redirect: bubble whose PC points at the handler, not in a delay slot.
                nxt    = '0;
                nxt.pc = EXC_PC;
            end
            ACT_FLUSH: begin
                // Bubble that still carries PC and delay-slot flag so EPC can be derived later.
                nxt    = '0;
                nxt.pc = in_pc;
                nxt.bd = in_bd;
            end
            ACT_HOLD: begin
                // Contents freeze, but the producer keeps making progress so T_new still ages.
                nxt.tnew = tnew_dec(cur_q.tnew);
                nxt_hold = (hold_q == HOLD_MAX) ? HOLD_MAX : (hold_q + 8'd1);
            end
            default: begin
                nxt.valid   = in_valid;
                nxt.pc      = in_pc;
                nxt.instr   = in_instr;
                nxt.data    = in_data;
                nxt.bd      = in_bd;
                nxt.exccode = in_exccode;
                // An empty slot produces nothing, so it must never look like a pending result.
                nxt.tnew    = in_valid ? tnew_dec(in_tnew) : '0;
            end
        endcase
    end

    // Stage register with synchronous reset that overrides every other control.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q  <= '0;
            hold_q <= 8'd0;
        end else begin
            cur_q  <= nxt;
            hold_q <= nxt_hold;
        end
    end

    assign out_valid    = cur_q.valid;
    assign out_pc       = cur_q.pc;
    assign out_instr    = cur_q.instr;
    assign out_tnew     = cur_q.tnew;
    assign out_data     = cur_q.data;
    assign out_bd       = cur_q.bd;
    assign out_exccode  = cur_q.exccode;
    assign out_hold_cnt = hold_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one hold-mode and one bubble-mode instance share the stimulus.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants for every step.
module tb_pipe_stage_reg;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int TW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                stall;
    logic                flush;
    logic                req;
    logic                in_valid;
    logic [31:0]         in_pc;
    logic [31:0]         in_instr;
    logic [TW-1:0]       in_tnew;
    logic [NCH*DW-1:0]   in_data;
    logic                in_bd;
    logic [4:0]          in_exccode;

    logic                o0_valid, o1_valid;
    logic [31:0]         o0_pc, o1_pc;
    logic [31:0]         o0_instr, o1_instr;
    logic [TW-1:0]       o0_tnew, o1_tnew;
    logic [NCH*DW-1:0]   o0_data, o1_data;
    logic                o0_bd, o1_bd;
    logic [4:0]          o0_exc, o1_exc;
    logic [7:0]          o0_hold, o1_hold;

    int checks   = 0;
    int failures = 0;

    localparam logic [NCH*DW-1:0] D1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    localparam logic [NCH*DW-1:0] D2 = {32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h1234_5678, 32'hCAFE_F00D};
    localparam logic [NCH*DW-1:0] DZ = '0;
    localparam logic [31:0] I0 = 32'h8C01_0004;
    localparam logic [31:0] I1 = 32'h0043_2021;
    localparam logic [31:0] I2 = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DW(DW), .NCH(NCH), .TW(TW), .STALL_MODE(0), .EXC_PC(32'h0000_4180)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_tnew(in_tnew),
        .in_data(in_data), .in_bd(in_bd), .in_exccode(in_exccode),
        .out_valid(o0_valid), .out_pc(o0_pc), .out_instr(o0_instr), .out_tnew(o0_tnew),
        .out_data(o0_data), .out_bd(o0_bd), .out_exccode(o0_exc), .out_hold_cnt(o0_hold)
    );

    pipe_stage_reg #(.DW(DW), .NCH(NCH), .TW(TW), .STALL_MODE(1), .EXC_PC(32'h0000_4180)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_tnew(in_tnew),
        .in_data(in_data), .in_bd(in_bd), .in_exccode(in_exccode),
        .out_valid(o1_valid), .out_pc(o1_pc), .out_instr(o1_instr), .out_tnew(o1_tnew),
        .out_data(o1_data), .out_bd(o1_bd), .out_exccode(o1_exc), .out_hold_cnt(o1_hold)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output of instance sel (0 = hold mode, 1 = bubble mode) against expectations.
    task automatic chk(input bit sel, input string tag,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                       input logic [TW-1:0] etn, input logic [NCH*DW-1:0] ed,
                       input logic eb, input logic [4:0] ee, input logic [7:0] eh);
        logic              ov;
        logic [31:0]       opc;
        logic [31:0]       oin;
        logic [TW-1:0]     otn;
        logic [NCH*DW-1:0] od;
        logic              ob;
        logic [4:0]        oe;
        logic [7:0]        oh;
        if (sel) begin
            ov = o1_valid; opc = o1_pc; oin = o1_instr; otn = o1_tnew;
            od = o1_data;  ob = o1_bd;  oe = o1_exc;    oh = o1_hold;
        end else begin
            ov = o0_valid; opc = o0_pc; oin = o0_instr; otn = o0_tnew;
            od = o0_data;  ob = o0_bd;  oe = o0_exc;    oh = o0_hold;
        end
        checks++;
        assert (ov === ev) else begin failures++; $error("FAIL %s/m%0d.valid observed=%0h expected=%0h", tag, sel, ov, ev); end
        checks++;
        assert (opc === epc) else begin failures++; $error("FAIL %s/m%0d.pc observed=%0h expected=%0h", tag, sel, opc, epc); end
        checks++;
        assert (oin === ein) else begin failures++; $error("FAIL %s/m%0d.instr observed=%0h expected=%0h", tag, sel, oin, ein); end
        checks++;
        assert (otn === etn) else begin failures++; $error("FAIL %s/m%0d.tnew observed=%0h expected=%0h", tag, sel, otn, etn); end
        checks++;
        assert (od === ed) else begin failures++; $error("FAIL %s/m%0d.data observed=%0h expected=%0h", tag, sel, od, ed); end
        checks++;
        assert (ob === eb) else begin failures++; $error("FAIL %s/m%0d.bd observed=%0h expected=%0h", tag, sel, ob, eb); end
        checks++;
        assert (oe === ee) else begin failures++; $error("FAIL %s/m%0d.exccode observed=%0h expected=%0h", tag, sel, oe, ee); end
        checks++;
        assert (oh === eh) else begin failures++; $error("FAIL %s/m%0d.hold_cnt observed=%0h expected=%0h", tag, sel, oh, eh); end
    endtask

    initial begin
        // Reset with every other control and input active: all outputs must clear.
        reset = 1'b1; stall = 1'b1; flush = 1'b0; req = 1'b0;
        in_valid = 1'b1; in_pc = 32'h1234; in_instr = I0; in_tnew = 2'd3;
        in_data = D1; in_bd = 1'b1; in_exccode = 5'd5;
        tick();
        chk(0, "reset", 1'b0, 32'h0, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);
        chk(1, "reset", 1'b0, 32'h0, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);

        // Plain load, T_new 2 -> 1.
        reset = 1'b0; stall = 1'b0;
        in_pc = 32'h3000; in_tnew = 2'd2; in_bd = 1'b0; in_exccode = 5'd0;
        tick();
        chk(0, "load", 1'b1, 32'h3000, I0, 2'd1, D1, 1'b0, 5'd0, 8'd0);
        chk(1, "load", 1'b1, 32'h3000, I0, 2'd1, D1, 1'b0, 5'd0, 8'd0);

        // Load T_new 3 -> 2, then stall three cycles with different upstream contents.
        in_pc = 32'h3004; in_instr = I1; in_tnew = 2'd3;
        tick();
        chk(0, "load3", 1'b1, 32'h3004, I1, 2'd2, D1, 1'b0, 5'd0, 8'd0);
        stall = 1'b1; in_pc = 32'h3008; in_bd = 1'b1; in_instr = I2; in_data = D2; in_exccode = 5'd3;
        tick();
        chk(0, "hold1", 1'b1, 32'h3004, I1, 2'd1, D1, 1'b0, 5'd0, 8'd1);
        chk(1, "bubble", 1'b0, 32'h3008, 32'h0, 2'd0, DZ, 1'b1, 5'd0, 8'd0);
        tick();
        chk(0, "hold2", 1'b1, 32'h3004, I1, 2'd0, D1, 1'b0, 5'd0, 8'd2);
        tick();
        chk(0, "hold3", 1'b1, 32'h3004, I1, 2'd0, D1, 1'b0, 5'd0, 8'd3);
        chk(1, "bubble3", 1'b0, 32'h3008, 32'h0, 2'd0, DZ, 1'b1, 5'd0, 8'd0);

        // Flush beats stall and clears the hold counter.
        flush = 1'b1; in_pc = 32'h5004;
        tick();
        chk(0, "flush_stall", 1'b0, 32'h5004, 32'h0, 2'd0, DZ, 1'b1, 5'd0, 8'd0);
        chk(1, "flush_stall", 1'b0, 32'h5004, 32'h0, 2'd0, DZ, 1'b1, 5'd0, 8'd0);

        // req beats flush and stall: redirect to the exception vector.
        req = 1'b1; in_pc = 32'h5000;
        tick();
        chk(0, "req", 1'b0, 32'h4180, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);
        chk(1, "req", 1'b0, 32'h4180, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);

        // Load of an empty slot: fields copied, valid and T_new forced low.
        req = 1'b0; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_pc = 32'h3100; in_instr = I0; in_tnew = 2'd3;
        in_data = D1; in_bd = 1'b0; in_exccode = 5'd6;
        tick();
        chk(0, "load_inv", 1'b0, 32'h3100, I0, 2'd0, D1, 1'b0, 5'd6, 8'd0);
        chk(1, "load_inv", 1'b0, 32'h3100, I0, 2'd0, D1, 1'b0, 5'd6, 8'd0);

        // Flush to a bubble, then hold the bubble for two cycles.
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b1;
        tick();
        tick();
        chk(0, "held_bubble", 1'b0, 32'h3100, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd2);
        chk(1, "held_bubble", 1'b0, 32'h3100, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);

        // Load with T_new 0 stays 0; then 300 stall cycles saturate the counter.
        stall = 1'b0; in_valid = 1'b1; in_pc = 32'h3200; in_instr = I1; in_tnew = 2'd0;
        in_exccode = 5'd0;
        tick();
        chk(0, "tnew0", 1'b1, 32'h3200, I1, 2'd0, D1, 1'b0, 5'd0, 8'd0);
        stall = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        chk(0, "saturate", 1'b1, 32'h3200, I1, 2'd0, D1, 1'b0, 5'd0, 8'd255);
        chk(1, "sat_bubble", 1'b0, 32'h3200, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);

        // Reset in the middle of a stall, then a normal load right after release.
        stall = 1'b0; in_pc = 32'h3300; in_tnew = 2'd3;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk(0, "pre_reset", 1'b1, 32'h3300, I1, 2'd0, D1, 1'b0, 5'd0, 8'd5);
        reset = 1'b1;
        tick();
        chk(0, "mid_reset", 1'b0, 32'h0, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);
        chk(1, "mid_reset", 1'b0, 32'h0, 32'h0, 2'd0, DZ, 1'b0, 5'd0, 8'd0);
        reset = 1'b0; stall = 1'b0; in_pc = 32'h3010; in_instr = I0; in_tnew = 2'd2;
        tick();
        chk(0, "post_reset", 1'b1, 32'h3010, I0, 2'd1, D1, 1'b0, 5'd0, 8'd0);
        chk(1, "post_reset", 1'b1, 32'h3010, I0, 2'd1, D1, 1'b0, 5'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
Parameters (name, default, meaning):
REQ-001 DW, 32, width of one data channel.
REQ-002 NCH, 4, number of data channels (V1, V2, imm32, spare, ...).
REQ-003 TW, 2, width of the T_new field.
REQ-004 STALL_MODE, 0, stall behaviour: 0 = hold contents; 1 = insert bubble (legacy D/E behaviour).
REQ-005 EXC_PC, 32'h0000_4180, PC loaded on interrupt/exception request.

Ports (name, direction, width, meaning):
REQ-006 clk, in, 1, single clock; all state updates on the rising edge.
REQ-007 reset, in, 1, synchronous, active-high reset.
REQ-008 stall, in, 1, stage stall request from the hazard unit.
REQ-009 flush, in, 1, turn the next stage content into a bubble.
REQ-010 req, in, 1, interrupt/exception request; flush and redirect to EXC_PC.
REQ-011 in_valid, in, 1, upstream slot holds a real instruction.
REQ-012 in_pc / in_instr, in, 32 each, upstream PC and instruction.
REQ-013 in_tnew, in, TW, cycles until the upstream result is available.
REQ-014 in_data, in, NCH*DW, packed data channels; channel k = bits [k*DW +: DW].
REQ-015 in_bd, in, 1, instruction sits in a branch delay slot.
REQ-016 in_exccode, in, 5, pending exception code (0 = none).
REQ-017 out_valid, out_pc, out_instr, out_tnew, out_data, out_bd, out_exccode, out, matching widths, registered stage contents.
REQ-018 out_hold_cnt, out, 8, consecutive cycles the current content has been held.

Function
REQ-019 Per-edge priority: reset > req > flush > stall > load.
REQ-020 Bubble: out_valid=0, out_instr=0, out_data=0, out_tnew=0, out_exccode=0, out_hold_cnt=0.
REQ-021 req=1: bubble; out_pc=EXC_PC; out_bd=0.
REQ-022 flush=1, req=0: bubble; out_pc=in_pc; out_bd=in_bd (keeps EPC information valid).
REQ-023 stall=1, STALL_MODE=1: identical to flush (REQ-022).
REQ-024 stall=1, STALL_MODE=0: all outputs hold, except out_tnew <= (out_tnew>0) ? out_tnew-1 : 0, and out_hold_cnt increments, saturating at 255.
REQ-025 Load, no control active: all fields copied; out_tnew <= (in_tnew>0) ? in_tnew-1 : 0; out_hold_cnt <= 0.
REQ-026 Load with in_valid=0: fields copied, out_valid=0, and out_tnew forced to 0.
REQ-027 T_new arithmetic is unsigned on TW bits; it never wraps below 0.
REQ-028 Latency: one cycle from input to output; no combinational path from inputs to outputs.
REQ-029 Simultaneous stall and flush: flush wins and clears out_hold_cnt.
REQ-030 Held bubble (STALL_MODE=0): stays a bubble; out_hold_cnt still counts.

Reset
REQ-031 reset=1 at an edge sets every output to 0, including out_pc and out_hold_cnt, regardless of all other inputs.
REQ-032 A reset asserted mid-stall drops the held content; the first edge after reset releases performs a normal load.

Verification
REQ-033 Load: in_pc=0x3000, in_tnew=2, in_valid=1, ch0=0xDEADBEEF -> next cycle out_pc=0x3000, out_tnew=1, out_valid=1, ch0=0xDEADBEEF.
REQ-034 Hold (MODE 0): load in_tnew=3, then stall for 3 cycles -> out_tnew goes 2,1,0,0; out_hold_cnt goes 0,1,2,3; the other fields are unchanged.
REQ-035 Bubble (MODE 1): stall=1 with in_pc=0x3008, in_bd=1 -> out_valid=0, out_instr=0, out_pc=0x3008, out_bd=1.
REQ-036 Priority: req=flush=stall=1 -> out_pc=0x4180, out_valid=0, out_bd=0; flush=stall=1 -> out_pc=in_pc and out_hold_cnt=0.
REQ-037 Saturation: 300 stall cycles -> out_hold_cnt=255; in_tnew=0 loaded -> out_tnew=0.
REQ-038 Reset mid-stall: after 5 stall cycles, reset=1 -> all outputs 0; release, then load in_pc=0x3010 -> out_pc=0x3010.
